// File: rtl/hp_pkg.sv
// Shared types and constants for the player HP tracker and its bar renderer.
package hp_pkg;

    // Player life-cycle state
    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } hp_state_e;

    // 12-bit RGB (4:4:4) colours used by the HP bar
    localparam logic [11:0] HP_YELLOW = 12'hFF0;
    localparam logic [11:0] HP_RED    = 12'hF00;
    localparam logic [11:0] HP_FLASH  = 12'hFFF;
    localparam logic [11:0] HP_NONE   = 12'h000;

    // Width of the invulnerability down-counter; wide enough for several seconds at 65 MHz
    localparam int unsigned HP_CNT_W = 32;

endpackage

// File: rtl/hp_bar_render.sv
// Purely combinational HP bar: a MAX_HP-wide rectangle, filled yellow up to the
// current HP and red beyond it. Output is zero outside the rectangle so it can be
// summed with other sprite layers.
module hp_bar_render
    import hp_pkg::*;
#(
    parameter int unsigned MAX_HP     = 20,
    parameter int unsigned BAR_X      = 432,
    parameter int unsigned BAR_Y      = 472,
    parameter int unsigned BAR_UNIT_W = 8,
    parameter int unsigned BAR_H      = 16
) (
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [7:0]  hp_in,
    input  logic        flash_in,
    output logic [11:0] pixel_out
);

    // Rectangle bounds, held in 32 bits so no sum can wrap
    localparam logic [31:0] X_LO = 32'(BAR_X);
    localparam logic [31:0] X_HI = 32'(BAR_X + MAX_HP * BAR_UNIT_W);
    localparam logic [31:0] Y_LO = 32'(BAR_Y);
    localparam logic [31:0] Y_HI = 32'(BAR_Y + BAR_H);

    logic [31:0] x_w;
    logic [31:0] y_w;
    logic [31:0] fill_end_w;
    logic        in_rect_w;
    logic        in_fill_w;

    // Widen coordinates and locate the end of the filled (alive) section
    always_comb begin
        x_w        = {21'd0, hcount_in};
        y_w        = {22'd0, vcount_in};
        fill_end_w = X_LO + ({24'd0, hp_in} * 32'(BAR_UNIT_W));
        in_rect_w  = (x_w >= X_LO) && (x_w < X_HI) && (y_w >= Y_LO) && (y_w < Y_HI);
        in_fill_w  = (x_w < fill_end_w);
    end

    // Colour select: flash only replaces the filled part, the red remainder is steady
    always_comb begin
        pixel_out = HP_NONE;
        if (in_rect_w) begin
            if (in_fill_w) begin
                pixel_out = flash_in ? HP_FLASH : HP_YELLOW;
            end else begin
                pixel_out = HP_RED;
            end
        end
    end

endmodule

// File: rtl/hp_tracker.sv
// Player HP tracker: accepts one-cycle damage pulses, applies invulnerability
// frames after each accepted hit, reports death, and draws the HP bar.
module hp_tracker
    import hp_pkg::*;
#(
    parameter int unsigned MAX_HP        = 20,
    parameter int unsigned DAMAGE_AMT    = 4,
    parameter int unsigned IFRAME_CYCLES = 32_500_000,
    parameter int unsigned FLASH_BIT     = 22,
    parameter int unsigned BAR_X         = 432,
    parameter int unsigned BAR_Y         = 472,
    parameter int unsigned BAR_UNIT_W    = 8,
    parameter int unsigned BAR_H         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        damage_in,
    input  logic        restart_in,
    output logic [7:0]  hp_out,
    output logic        invuln_out,
    output logic        dead_out,
    output logic        died_out,
    output logic [11:0] pixel_out
);

    localparam logic [7:0]          HP_FULL  = 8'(MAX_HP);
    localparam logic [7:0]          HP_DMG   = 8'(DAMAGE_AMT);
    localparam logic [HP_CNT_W-1:0] CNT_LOAD = HP_CNT_W'(IFRAME_CYCLES - 1);

    hp_state_e           state_q;
    logic [7:0]          hp_q;
    logic [7:0]          hp_hit_d;
    logic [HP_CNT_W-1:0] cnt_q;
    logic                invuln_q;
    logic                dead_q;
    logic                died_q;
    logic                flash_d;

    // HP after a hit, clamped at zero instead of wrapping
    always_comb begin
        hp_hit_d = (hp_q <= HP_DMG) ? 8'd0 : (hp_q - HP_DMG);
    end

    // Life-cycle FSM with HP, i-frame counter and registered status outputs.
    // The counter is loaded with IFRAME_CYCLES-1 and INVULN exits the cycle after
    // it reads zero, so INVULN lasts exactly IFRAME_CYCLES clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ALIVE;
            hp_q     <= HP_FULL;
            cnt_q    <= '0;
            invuln_q <= 1'b0;
            dead_q   <= 1'b0;
            died_q   <= 1'b0;
        end else begin
            died_q <= 1'b0;
            if (restart_in) begin
                state_q  <= ALIVE;
                hp_q     <= HP_FULL;
                cnt_q    <= '0;
                invuln_q <= 1'b0;
                dead_q   <= 1'b0;
            end else begin
                case (state_q)
                    ALIVE: begin
                        if (damage_in) begin
                            hp_q <= hp_hit_d;
                            if (hp_hit_d == 8'd0) begin
                                state_q <= DEAD;
                                dead_q  <= 1'b1;
                                died_q  <= 1'b1;
                            end else begin
                                state_q  <= INVULN;
                                cnt_q    <= CNT_LOAD;
                                invuln_q <= 1'b1;
                            end
                        end
                    end
                    INVULN: begin
                        // damage is ignored for the whole window, including its last cycle
                        if (cnt_q == '0) begin
                            state_q  <= ALIVE;
                            invuln_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    DEAD: begin
                        hp_q <= 8'd0;
                    end
                    default: begin
                        state_q  <= ALIVE;
                        hp_q     <= HP_FULL;
                        cnt_q    <= '0;
                        invuln_q <= 1'b0;
                        dead_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Bar blinks while invulnerable, driven by one bit of the i-frame counter
    always_comb begin
        flash_d = (state_q == INVULN) && cnt_q[FLASH_BIT];
    end

    assign hp_out     = hp_q;
    assign invuln_out = invuln_q;
    assign dead_out   = dead_q;
    assign died_out   = died_q;

    hp_bar_render #(
        .MAX_HP     (MAX_HP),
        .BAR_X      (BAR_X),
        .BAR_Y      (BAR_Y),
        .BAR_UNIT_W (BAR_UNIT_W),
        .BAR_H      (BAR_H)
    ) u_bar (
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .hp_in     (hp_q),
        .flash_in  (flash_d),
        .pixel_out (pixel_out)
    );

endmodule

// File: tb/tb_hp_tracker.sv
// Scoreboard bench for hp_tracker: stimulus pushes hand-computed expectations
// tagged with the cycle they apply to; a monitor pops and compares them.
module tb_hp_tracker;

    localparam int BX = 432;
    localparam int BY = 472;

    logic        clk;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        damage, restart, damage6, restart6;
    logic [7:0]  hp_a, hp_b;
    logic        inv_a, dead_a, died_a, inv_b, dead_b, died_b;
    logic [11:0] pix_a, pix_b;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int          tgt;
        bit          is_pix;
        bit          u6;
        string       name;
        logic [7:0]  hp;
        logic        inv;
        logic        dead;
        logic        died;
        logic [11:0] pix;
    } exp_t;

    exp_t q[$];

    // Main instance: short i-frames and a low flash bit so blinking is observable
    hp_tracker #(
        .MAX_HP(20), .DAMAGE_AMT(4), .IFRAME_CYCLES(10), .FLASH_BIT(2),
        .BAR_X(BX), .BAR_Y(BY), .BAR_UNIT_W(8), .BAR_H(16)
    ) dut (
        .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
        .damage_in(damage), .restart_in(restart),
        .hp_out(hp_a), .invuln_out(inv_a), .dead_out(dead_a), .died_out(died_a),
        .pixel_out(pix_a)
    );

    // Second instance with MAX_HP=6 for the clamp-at-zero case
    hp_tracker #(
        .MAX_HP(6), .DAMAGE_AMT(4), .IFRAME_CYCLES(10), .FLASH_BIT(2),
        .BAR_X(BX), .BAR_Y(BY), .BAR_UNIT_W(8), .BAR_H(16)
    ) dut6 (
        .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
        .damage_in(damage6), .restart_in(restart6),
        .hp_out(hp_b), .invuln_out(inv_b), .dead_out(dead_b), .died_out(died_b),
        .pixel_out(pix_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_st(input string nm, input bit u6, input int hp,
                           input bit inv, input bit dead, input bit died, input int dt);
        exp_t e;
        e.tgt = cyc + dt; e.is_pix = 1'b0; e.u6 = u6; e.name = nm;
        e.hp = 8'(hp); e.inv = inv; e.dead = dead; e.died = died; e.pix = '0;
        q.push_back(e);
    endtask

    task automatic push_px(input string nm, input int x, input int y, input logic [11:0] px);
        exp_t e;
        hcount = 11'(x);
        vcount = 10'(y);
        e.tgt = cyc; e.is_pix = 1'b1; e.u6 = 1'b0; e.name = nm;
        e.hp = '0; e.inv = 1'b0; e.dead = 1'b0; e.died = 1'b0; e.pix = px;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        damage = 1'b0; restart = 1'b0; damage6 = 1'b0; restart6 = 1'b0;
    endtask

    // One accepted hit followed by idle cycles; hpa is the HP after the hit
    task automatic hit_group(input bit u6, input int hpa, input int nc, input string nm);
        if (u6) damage6 = 1'b1; else damage = 1'b1;
        for (int c = 1; c <= nc; c++) begin
            push_st(nm, u6, hpa, (hpa != 0) && (c <= 10), hpa == 0, (hpa == 0) && (c == 1), 1);
            step();
        end
    endtask

    // Monitor: compare every expectation that has come due
    initial begin
        forever begin
            @(negedge clk or posedge rst);
            #1;
            begin
                int i;
                i = 0;
                while (i < q.size()) begin
                    if (q[i].tgt <= cyc) begin
                        exp_t e;
                        e = q[i];
                        total++;
                        if (e.is_pix) begin
                            if (pix_a !== e.pix) begin
                                bad++;
                                $display("FAIL %s cyc=%0d x=%0d y=%0d pixel got %h want %h",
                                         e.name, cyc, hcount, vcount, pix_a, e.pix);
                            end
                        end else begin
                            logic [7:0] ghp;
                            logic gi, gd, gdi;
                            ghp = e.u6 ? hp_b : hp_a;
                            gi  = e.u6 ? inv_b : inv_a;
                            gd  = e.u6 ? dead_b : dead_a;
                            gdi = e.u6 ? died_b : died_a;
                            if (ghp !== e.hp || gi !== e.inv || gd !== e.dead || gdi !== e.died) begin
                                bad++;
                                $display("FAIL %s cyc=%0d got hp=%0d inv=%b dead=%b died=%b want hp=%0d inv=%b dead=%b died=%b",
                                         e.name, cyc, ghp, gi, gd, gdi, e.hp, e.inv, e.dead, e.died);
                            end
                        end
                        q.delete(i);
                    end else begin
                        i++;
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1; hcount = '0; vcount = '0;
        damage = 1'b0; restart = 1'b0; damage6 = 1'b0; restart6 = 1'b0;

        // reset values while reset is held
        @(posedge clk); #1;
        push_st("reset", 0, 20, 0, 0, 0, 0);
        push_st("reset6", 1, 6, 0, 0, 0, 0);
        step();
        rst = 1'b0;

        // idle: nothing changes, died never pulses
        for (int i = 0; i < 100; i++) begin
            push_st("idle", 0, 20, 0, 0, 0, 1);
            step();
        end

        // single hit, damage during INVULN, damage on the last INVULN cycle
        damage = 1'b1;
        push_st("hit1", 0, 16, 1, 0, 0, 1);
        step();
        for (int c = 2; c <= 12; c++) begin
            if (c == 6 || c == 11) damage = 1'b1;
            push_st("iframe", 0, 16, c <= 10, 0, 0, 1);
            step();
        end

        // full game over from 20 HP
        restart = 1'b1;
        push_st("restart", 0, 20, 0, 0, 0, 1);
        step();
        hit_group(0, 16, 12, "h1");
        hit_group(0, 12, 12, "h2");
        hit_group(0, 8, 12, "h3");
        hit_group(0, 4, 12, "h4");
        hit_group(0, 0, 3, "h5");
        damage = 1'b1;
        push_st("dead_dmg", 0, 0, 0, 1, 0, 1);
        step();
        push_st("dead_hold", 0, 0, 0, 1, 0, 1);
        step();

        // restart beats simultaneous damage
        restart = 1'b1; damage = 1'b1;
        push_st("restart_dmg", 0, 20, 0, 0, 0, 1);
        step();
        push_st("after_restart", 0, 20, 0, 0, 0, 1);
        step();

        // MAX_HP=6: 6 -> 2 -> 0 (clamped)
        hit_group(1, 2, 12, "c1");
        hit_group(1, 0, 2, "c2");
        damage6 = 1'b1;
        push_st("c_dead_dmg", 1, 0, 0, 1, 0, 1);
        step();

        // asynchronous reset mid-INVULN (main) and in DEAD (second instance)
        damage = 1'b1;
        push_st("pre_rst", 0, 16, 1, 0, 0, 1);
        step();
        step();
        @(negedge clk); #2;
        push_st("async_rst", 0, 20, 0, 0, 0, 0);
        push_st("async_rst6", 1, 6, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_st("post_rst", 0, 20, 0, 0, 0, 1);
        push_st("post_rst6", 1, 6, 0, 0, 0, 1);
        step();

        // HP bar at hp=12
        hit_group(0, 16, 12, "p1");
        hit_group(0, 12, 12, "p2");
        push_px("px_fill_end", BX + 95, BY, 12'hFF0); step();
        push_px("px_red_start", BX + 96, BY, 12'hF00); step();
        push_px("px_right_out", BX + 160, BY, 12'h000); step();
        push_px("px_below", BX, BY + 16, 12'h000); step();
        push_px("px_left_out", BX - 1, BY, 12'h000); step();
        push_px("px_corner", BX + 159, BY + 15, 12'hF00); step();
        push_px("px_bot_left", BX, BY + 15, 12'hFF0); step();

        // flashing during INVULN at hp=8 (counter 9,8,7.. ; bit 2 set for 7..4)
        hcount = '0; vcount = '0;
        damage = 1'b1;
        push_st("flash_hit", 0, 8, 1, 0, 0, 1);
        step();                                        // cnt=9
        step();                                        // cnt=8
        step();                                        // cnt=7
        push_px("px_flash", BX, BY, 12'hFFF); step();  // cnt=6
        push_px("px_flash_red", BX + 64, BY, 12'hF00); step();  // cnt=5
        push_px("px_flash_edge", BX + 63, BY, 12'hFFF); step(); // cnt=4
        step();                                        // cnt=3
        push_px("px_noflash", BX, BY, 12'hFF0); step();
        hcount = '0; vcount = '0;

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
